sync_fifo_thresh: RTL

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is the single-clock generation of the FIFO family, for buffering between blocks that share one clock domain. Storage is an internal register array. Read data is registered.

---
 rtl/sync_fifo_thresh_if.sv | 38 +++
 rtl/sync_fifo_thresh.sv | 117 +++++++++++
 2 files changed

// File: rtl/sync_fifo_thresh_if.sv
// ============================================================================
// Module   : sync_fifo_thresh_if
// Brief    : Request/status bundle between a FIFO user and sync_fifo_thresh.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sync_fifo_thresh_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  w_inc;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd_inc;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full_flag;
  logic                  empty_flag;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fill_level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, w_inc, w_data, rd_inc,
    input  rd_data, full_flag, empty_flag, almost_full, almost_empty,
           fill_level, overflow, underflow
  );

  modport slave (
    input  clr, w_inc, w_data, rd_inc,
    output rd_data, full_flag, empty_flag, almost_full, almost_empty,
           fill_level, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_thresh.sv
// ============================================================================
// Module   : sync_fifo_thresh
// Brief    : Single-clock FIFO with level, AF/AE thresholds, sticky errors, flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_thresh #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_TH      = 12,
  parameter int AE_TH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_thresh_if.slave    fifo
);

  localparam int                  c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_ONE     = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] c_DEPTH_L = (ADDR_WIDTH + 1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AF_TH   = (ADDR_WIDTH + 1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] c_AE_TH   = (ADDR_WIDTH + 1)'(AE_TH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_level_next;

  // Acceptance is judged on the registered flags only; no write-through path.
  assign w_wr_acc = fifo.w_inc  && !r_full  && !fifo.clr;
  assign w_rd_acc = fifo.rd_inc && !r_empty && !fifo.clr;

  always_comb begin
    w_level_next = r_level;
    if (w_wr_acc && !w_rd_acc) begin
      w_level_next = r_level + c_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_next = r_level - c_ONE;
    end
  end

  // Storage is intentionally unreset; it is never readable before a write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= fifo.w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_rd_data      <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else if (fifo.clr) begin
      // Flush keeps rd_data and the array; only bookkeeping is cleared.
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + c_ONE;
        r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
      r_level        <= w_level_next;
      r_full         <= (w_level_next == c_DEPTH_L);
      r_empty        <= (w_level_next == '0);
      r_almost_full  <= (w_level_next >= c_AF_TH);
      r_almost_empty <= (w_level_next <= c_AE_TH);
      if (fifo.w_inc && r_full) begin
        r_overflow <= 1'b1;
      end
      if (fifo.rd_inc && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign fifo.rd_data      = r_rd_data;
  assign fifo.fill_level   = r_level;
  assign fifo.full_flag    = r_full;
  assign fifo.empty_flag   = r_empty;
  assign fifo.almost_full  = r_almost_full;
  assign fifo.almost_empty = r_almost_empty;
  assign fifo.overflow     = r_overflow;
  assign fifo.underflow    = r_underflow;

endmodule

`default_nettype wire
